// File: rtl/mem_lane_unit.sv
// Load/store lane unit: registers one request, drives lane-aligned memory strobes,
// and returns right-aligned, extended load data. Misaligned accesses never reach memory.
module mem_lane_unit #(
    parameter int WORD_BYTES = 2,
    parameter int ADDR_WIDTH = 16,
    localparam int DATA_W = 8 * WORD_BYTES,
    localparam int OFF_W  = $clog2(WORD_BYTES),
    localparam int SIZE_W = OFF_W + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [SIZE_W-1:0]     req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [WORD_BYTES-1:0] mem_byte_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_resp,
    output logic                  resp_valid,
    output logic                  resp_misaligned,
    output logic [DATA_W-1:0]     resp_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state;
    logic              write_q;
    logic              signed_q;
    logic [SIZE_W-1:0] size_q;
    logic [OFF_W-1:0]  off_q;

    // Low 2**size lanes set; only meaningful when the size fits in a word.
    function automatic logic [WORD_BYTES-1:0] lane_mask(input logic [SIZE_W-1:0] size);
        logic [WORD_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < WORD_BYTES; i++)
            if (i < (1 << size)) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] byte_mask(input logic [SIZE_W-1:0] size);
        logic [WORD_BYTES-1:0] lanes;
        logic [DATA_W-1:0]     m;
        lanes = lane_mask(size);
        m = '0;
        for (int i = 0; i < WORD_BYTES; i++)
            m[8*i +: 8] = {8{lanes[i]}};
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] data,
                                                 input logic [SIZE_W-1:0] size,
                                                 input logic              sgn);
        logic [DATA_W-1:0] m;
        logic [7:0]        top;
        m   = byte_mask(size);
        top = '0;
        for (int i = 0; i < WORD_BYTES; i++)
            if (i == (1 << size) - 1) top = data[8*i +: 8];
        return (sgn && top[7]) ? ((data & m) | ~m) : (data & m);
    endfunction

    logic [OFF_W-1:0]      req_off;
    logic [WORD_BYTES-1:0] below_mask;
    logic                  req_misaligned;

    always_comb begin
        req_off        = req_addr[OFF_W-1:0];
        below_mask     = lane_mask(req_size) >> 1;
        req_misaligned = (req_size > SIZE_W'(OFF_W))
                      || ((WORD_BYTES'(req_off) & below_mask) != '0);
    end

    // Combinational on reset so the unit never advertises readiness while held in reset.
    assign req_ready = (state == IDLE) && !reset;

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            write_q         <= 1'b0;
            signed_q        <= 1'b0;
            size_q          <= '0;
            off_q           <= '0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_byte_enable <= '0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            resp_valid      <= 1'b0;
            resp_misaligned <= 1'b0;
            resp_rdata      <= '0;
        end else begin
            resp_valid      <= 1'b0;
            resp_misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        signed_q <= req_signed;
                        size_q   <= req_size;
                        off_q    <= req_off;
                        if (req_misaligned) begin
                            state           <= DONE;
                            resp_valid      <= 1'b1;
                            resp_misaligned <= 1'b1;
                            resp_rdata      <= '0;
                        end else begin
                            state           <= ACCESS;
                            mem_read        <= !req_write;
                            mem_write       <= req_write;
                            mem_byte_enable <= lane_mask(req_size) << req_off;
                            mem_address     <= {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                            mem_wdata       <= (req_wdata & byte_mask(req_size)) << {req_off, 3'b000};
                        end
                    end
                end
                ACCESS: begin
                    if (mem_resp) begin
                        state           <= DONE;
                        mem_read        <= 1'b0;
                        mem_write       <= 1'b0;
                        mem_byte_enable <= '0;
                        mem_address     <= '0;
                        mem_wdata       <= '0;
                        resp_valid      <= 1'b1;
                        resp_rdata      <= write_q ? '0
                                         : extend(mem_rdata >> {off_q, 3'b000}, size_q, signed_q);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
